// File: rtl/fe_cswap_seq.sv
// Constant-time conditional swap of two multi-limb field elements.
// One limb is masked-XOR-swapped per cycle; timing never depends on the swap bit.
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready high
// RUN   | walking limbs 0..NLIMB-1, one per cycle
// DONE  | result presented on f_out/g_out until out_ready
module fe_cswap_seq #(
    parameter int NLIMB = 10,
    parameter int LW    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NLIMB*LW-1:0]   f_in,
    input  logic [NLIMB*LW-1:0]   g_in,
    input  logic                  b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NLIMB*LW-1:0]   f_out,
    output logic [NLIMB*LW-1:0]   g_out,
    output logic                  busy
);

    localparam int KW = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NLIMB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [KW-1:0]  k;
    logic [LW-1:0]  f_l [NLIMB];
    logic [LW-1:0]  g_l [NLIMB];
    logic [LW-1:0]  m_reg;
    logic [LW-1:0]  x;

    // Mask is all-ones or all-zeros, so the same XOR work happens either way.
    assign x = (f_l[k] ^ g_l[k]) & m_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (k == K_LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NLIMB; i++) begin
                f_l[i] <= '0;
                g_l[i] <= '0;
            end
            m_reg <= '0;
            k     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NLIMB; i++) begin
                            f_l[i] <= f_in[i*LW +: LW];
                            g_l[i] <= g_in[i*LW +: LW];
                        end
                        m_reg <= {LW{b}};
                        k     <= '0;
                    end
                end
                RUN: begin
                    f_l[k] <= f_l[k] ^ x;
                    g_l[k] <= g_l[k] ^ x;
                    k      <= (k == K_LAST) ? '0 : k + KW'(1);
                end
                DONE: begin
                    if (out_ready) m_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NLIMB; i++) begin : g_pack
        assign f_out[i*LW +: LW] = f_l[i];
        assign g_out[i*LW +: LW] = g_l[i];
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fe_cswap_seq.sv
// Bench for fe_cswap_seq: directed and random operand sets checked against
// a swap-or-keep reference, plus latency, stall, reset-abort and throughput.
module tb_fe_cswap_seq;

    localparam int NLIMB = 10;
    localparam int LW    = 32;
    localparam int W     = NLIMB * LW;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] f_in;
    logic [W-1:0] g_in;
    logic         b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] f_out;
    logic [W-1:0] g_out;
    logic         busy;

    int errors = 0;
    int checks = 0;

    fe_cswap_seq #(.NLIMB(NLIMB), .LW(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f_in      (f_in),
        .g_in      (g_in),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_out     (f_out),
        .g_out     (g_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_elem();
        logic [W-1:0] v;
        for (int i = 0; i < NLIMB; i++) v[i*LW +: LW] = $urandom;
        return v;
    endfunction

    function automatic logic [W-1:0] fill_elem(input logic [LW-1:0] base, input logic step);
        logic [W-1:0] v;
        for (int i = 0; i < NLIMB; i++) v[i*LW +: LW] = step ? base + LW'(i) : base;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction. Caller sits at posedge+1 with the block idle.
    // While the block is busy the inputs are scrambled and in_valid pulsed
    // at random; none of that may disturb the captured operands.
    task automatic do_op(input string tag, input logic [W-1:0] f, input logic [W-1:0] g,
                         input logic bb, input int hold);
        logic [W-1:0] ef;
        logic [W-1:0] eg;
        int           lat;
        logic         busy_ok;
        ef = bb ? g : f;
        eg = bb ? f : g;
        check({tag, " in_ready before"}, W'(in_ready), W'(1));
        f_in = f; g_in = g; b = bb; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        check({tag, " busy after accept"}, W'({busy, out_valid, in_ready}), W'(3'b100));
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 30) begin
            f_in = rand_elem(); g_in = rand_elem(); b = 1'($urandom);
            in_valid = 1'($urandom);
            tick();
            lat++;
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, " latency"}, W'(lat), W'(10));
        check({tag, " busy held"}, W'(busy_ok), W'(1));
        check({tag, " f_out"}, f_out, ef);
        check({tag, " g_out"}, g_out, eg);
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'($urandom);
            tick();
            check({tag, " stall valid"}, W'({out_valid, in_ready}), W'(2'b10));
            check({tag, " stall f_out"}, f_out, ef);
            check({tag, " stall g_out"}, g_out, eg);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " after handshake"}, W'({busy, out_valid, in_ready}), W'(3'b001));
        check({tag, " f held in idle"}, f_out, ef);
    endtask

    initial begin
        logic [W-1:0] fa, ga, fr, gr;
        logic [W-1:0] ops_f [6];
        logic [W-1:0] ops_g [6];
        logic         ops_b [6];
        int           n_in, n_out, cyc, last_cyc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        f_in = '0; g_in = '0; b = 1'b0;
        #2;
        check("reset flags", W'({busy, out_valid, in_ready}), W'(3'b001));
        check("reset f_out", f_out, '0);
        check("reset g_out", g_out, '0);
        #10;
        rst_n = 1'b1;
        tick();

        fa = fill_elem(32'h0000_0001, 1'b1);
        ga = fill_elem(32'hFFFF_FFF1, 1'b1);
        do_op("swap b1", fa, ga, 1'b1, 0);
        do_op("keep b0", fa, ga, 1'b0, 0);
        do_op("stall7", fa, ga, 1'b1, 7);
        tick();
        check("single result", W'(out_valid), W'(0));

        for (int r = 0; r < 6; r++) begin
            do_op("random", rand_elem(), rand_elem(), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Abort mid-RUN: handshake, then four limbs done, reset mid-clock.
        f_in = rand_elem(); g_in = rand_elem(); b = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort flags", W'({busy, out_valid, in_ready}), W'(3'b001));
        check("abort f_out", f_out, '0);
        check("abort g_out", g_out, '0);
        #3;
        rst_n = 1'b1;
        tick();
        check("post-reset idle", W'({busy, out_valid, in_ready}), W'(3'b001));
        fr = fill_elem(32'h7FFF_FFFF, 1'b0);
        gr = fill_elem(32'h8000_0000, 1'b0);
        do_op("after reset", fr, gr, 1'b1, 0);

        // Back-to-back with in_valid held high and alternating b.
        for (int i = 0; i < 6; i++) begin
            ops_f[i] = rand_elem();
            ops_g[i] = rand_elem();
            ops_b[i] = 1'(i % 2);
        end
        n_in = 0; n_out = 0; cyc = 0; last_cyc = 0;
        out_ready = 1'b1;
        while (n_out < 6 && cyc < 200) begin
            if (in_ready) begin
                if (n_in < 6) begin
                    f_in = ops_f[n_in]; g_in = ops_g[n_in]; b = ops_b[n_in];
                    in_valid = 1'b1;
                    n_in++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
            cyc++;
            if (out_valid) begin
                check("b2b f_out", f_out, ops_b[n_out] ? ops_g[n_out] : ops_f[n_out]);
                check("b2b g_out", g_out, ops_b[n_out] ? ops_f[n_out] : ops_g[n_out]);
                if (n_out > 0) check("b2b interval", W'(cyc - last_cyc), W'(12));
                last_cyc = cyc;
                n_out++;
            end
        end
        check("b2b result count", W'(n_out), W'(6));
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
